// File: rtl/mm_pkg.sv
// Shared types and sizing for the matrixMultiplier operand feeder.
// Optional job counter in the top is enabled with MMF_STATS_EN.
package mm_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int N_DEF      = 2;

    typedef enum logic [1:0] {
        FILL,
        START,
        STREAM,
        WAIT_DONE
    } mmf_state_t;

    // One job is matrix A followed by matrix B, each n x n.
    function automatic int mmf_elems(input int n);
        return 2 * n * n;
    endfunction

    localparam int ELEMS_DEF = mmf_elems(N_DEF);

endpackage

// File: rtl/mmf_buffer.sv
// Operand store for one job: single write port from the host side and a
// registered read port that presents data_in one cycle after the address.
module mmf_buffer
    import mm_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ELEMS  = ELEMS_DEF,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [ELEMS];
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    // NOTE: the storage array has no reset; every entry is written before it
    // is read, so clearing it would only cost a reset fan-out per bit.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Outside a stream the read register is forced to zero so data_in idles low.
    always_comb begin
        rd_data_d = rd_en ? mem_q[rd_addr] : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/mm_operand_feeder.sv
// Buffers one A+B operand job from a valid/ready host stream, pulses st, then
// streams it to matrixMultiplier. Define MMF_STATS_EN to add the jobs_done port.
module mm_operand_feeder
    import mm_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int N      = N_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              mm_done,
    output logic              st,
    output logic [DATA_W-1:0] data_in,
    output logic              data_vld,
    output logic              busy
`ifdef MMF_STATS_EN
    ,
    output logic [15:0]       jobs_done
`endif
);

    localparam int ELEMS = mmf_elems(N);
    localparam int AW    = (ELEMS > 1) ? $clog2(ELEMS) : 1;
    localparam logic [AW-1:0] LAST = AW'(ELEMS - 1);

    mmf_state_t    state_q, state_d;
    logic [AW-1:0] count_q, count_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          in_ready_q, in_ready_d;
    logic          st_q, st_d;
    logic          data_vld_q, data_vld_d;
    logic          busy_q, busy_d;
    logic          wr_en;
    logic          rd_en;
    logic [AW-1:0] rd_addr;

    // NOTE: every signal gets its default before the case statement, so no
    // path through this block can leave a value unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        idx_d      = idx_q;
        st_d       = 1'b0;
        data_vld_d = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = idx_q + 1'b1;

        unique case (state_q)
            FILL: begin
                if (in_valid && in_ready_q) begin
                    wr_en = 1'b1;
                    if (count_q == LAST) begin
                        count_d = '0;
                        state_d = START;
                        st_d    = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            START: begin
                // Address leads the stream by one cycle through the read register.
                state_d    = STREAM;
                idx_d      = '0;
                rd_en      = 1'b1;
                rd_addr    = '0;
                data_vld_d = 1'b1;
            end
            STREAM: begin
                if (idx_q == LAST) begin
                    state_d = WAIT_DONE;
                end else begin
                    idx_d      = idx_q + 1'b1;
                    rd_en      = 1'b1;
                    data_vld_d = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (mm_done) begin
                    state_d = FILL;
                    count_d = '0;
                end
            end
            default: state_d = FILL;
        endcase

        in_ready_d = (state_d == FILL);
        busy_d     = (state_d != FILL);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops
    // sample their _d inputs from the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= FILL;
            count_q    <= '0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            st_q       <= 1'b0;
            data_vld_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            in_ready_q <= in_ready_d;
            st_q       <= st_d;
            data_vld_q <= data_vld_d;
            busy_q     <= busy_d;
        end
    end

    mmf_buffer #(
        .DATA_W (DATA_W),
        .ELEMS  (ELEMS),
        .AW     (AW)
    ) u_buffer (
        .clk     (clk),
        .rst     (rst),
        .we      (wr_en),
        .wr_addr (count_q),
        .wr_data (in_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (data_in)
    );

    assign in_ready = in_ready_q;
    assign st       = st_q;
    assign data_vld = data_vld_q;
    assign busy     = busy_q;

`ifdef MMF_STATS_EN
    logic [15:0] jobs_q, jobs_d;

    always_comb begin
        jobs_d = jobs_q;
        if (state_q == WAIT_DONE && mm_done) begin
            jobs_d = jobs_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            jobs_q <= '0;
        end else begin
            jobs_q <= jobs_d;
        end
    end

    assign jobs_done = jobs_q;
`endif

endmodule

// File: doc/mm_operand_feeder.md
# mm_operand_feeder

Upstream loader for `matrixMultiplier`. It accepts operand bytes from a host over a valid/ready stream and buffers one complete job: matrix A followed by matrix B, each row-major. When the job is complete and the multiplier is free, it issues a one-cycle `st` pulse. It then drives the operands onto the multiplier's `data_in` one element per clock, and waits for the multiplier's `done` before accepting the next job.

## Interface
- `DATA_W`, 8: operand width; matches multiplier `data_in`.
- `N`, 2: matrix dimension. Each job is `ELEMS = 2*N*N` operands.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: host operand valid.
- `in_ready`  out  1: feeder can accept an operand.
- `in_data`  in  DATA_W: host operand.
- `mm_done`  in  1: multiplier `done`, level-sensitive.
- `st`  out  1: start pulse to the multiplier.
- `data_in`  out  DATA_W: operand to the multiplier.
- `data_vld`  out  1: high while `data_in` carries a streamed operand.
- `busy`  out  1: high in every state except FILL.

## Operation
- FSM states: FILL, START, STREAM, WAIT_DONE. All outputs are registered.
- Reset values:
  - state = FILL, fill count = 0, stream index = 0.
  - `in_ready` = 0 while `rst` is asserted; `in_ready` = 1 from the first edge after release.
  - `st` = 0, `data_in` = 0, `data_vld` = 0, `busy` = 0.
- FILL:
  - `in_ready` = 1 while count < ELEMS.
  - A transfer occurs on `in_valid && in_ready`; `buf[count] <= in_data`, then count increments.
  - On the edge that accepts element ELEMS-1: `in_ready` drops to 0 and the FSM moves to START.
  - `in_valid` with `in_ready` = 0 is ignored; the host must hold its data.
- START: `st` = 1 for exactly one cycle, then go to STREAM with index = 0.
- STREAM:
  - `data_in = buf[index]`, `data_vld` = 1, index increments every cycle.
  - After element ELEMS-1, go to WAIT_DONE; `data_in` returns to 0 and `data_vld` to 0.
- WAIT_DONE:
  - Hold until `mm_done` is sampled 1, then go to FILL with count = 0.
  - `mm_done` sampled in any other state is ignored.
- Reset asserted mid-job: immediate return to reset values; a partially loaded or partially streamed job is discarded.
- Buffer contents are never cleared, only overwritten.

## Timing
- Call the edge that accepts the last operand T0.
  - `st` = 1 during cycle T0+1.
  - Element k is on `data_in` during cycle T0+2+k.
  - `data_vld` is high for exactly ELEMS consecutive cycles.
- If `mm_done` is already 1 at the first WAIT_DONE edge, exit after 1 cycle. The minimum gap from the last streamed element to `in_ready` = 1 is 2 cycles.
- Host throughput is 1 operand per clock during FILL. There are no bubbles when `in_valid` is held high.

## Configuration
- `MMF_STATS_EN`:
  - Defined: adds output `jobs_done` [15:0]. It resets to 0, increments on each WAIT_DONE→FILL transition, and wraps 0xFFFF→0x0000.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package `mm_pkg` holds:
  - the `DATA_W` default;
  - the state enum `mmf_state_t` (FILL, START, STREAM, WAIT_DONE);
  - `ELEMS` as a localparam function of `N`.
- One sub-module, `mmf_buffer`: ELEMS×DATA_W register file with a write port (addr, data, we) and a registered read port indexed by the stream index.
  - Read address leads the stream by one cycle, so `data_in` meets the T0+2+k timing.

## Test plan
- Reset: with `rst`=0 mid-STREAM, all outputs go to 0 immediately. After release, `in_ready`=1 and count=0.
- Basic job (N=2): push 1..8 back-to-back.
  - `st` is high exactly one cycle at T0+1.
  - `data_in` = 1,2,…,8 on cycles T0+2…T0+9, with `data_vld` high only on those cycles.
- Backpressure:
  - During STREAM/WAIT_DONE, `in_valid`=1 with data 0xAA is not accepted (`in_ready`=0).
  - After `mm_done` pulses, 0xAA is accepted as element 0 of the next job.
- Gapped host: push 8 operands with random `in_valid` gaps. The streamed order still equals the push order, and `st` fires one cycle after the 8th accept.
- Done handling:
  - `mm_done` held 1 from START onward: no return to FILL before WAIT_DONE.
  - `mm_done` arriving 50 cycles late: `busy` stays 1 for those 50 cycles.
- Stats (`MMF_STATS_EN`):
  - `jobs_done` reads 3 after three complete jobs.
  - Preloaded to 0xFFFF by forcing, one further job wraps it to 0.
